encrypt_pipe: RTL and testbench

ENCRYPT_PIPE -- requirements
Module: encrypt_pipe

---
 rtl/encrypt_pipe.sv | 119 +++++++++++
 tb/tb_encrypt_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_pipe.sv
// rtl/encrypt_pipe.sv - three-stage byte cipher: alphabetic shift then XOR with fixed or rotating key.
// S1 captures the byte and its classification, S2 applies the shift, S3 XORs and owns key rotation.
module encrypt_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] k1,
  input  logic [7:0] k2,
  input  logic [7:0] k3,
  input  logic [2:0] rot_freq,
  input  logic       shift_en,
  input  logic [3:0] shift_amt,
  input  logic       mode,
  output logic       v,
  output logic [7:0] dout
);

  logic       s1_v_q;
  logic [7:0] s1_byte_q;
  logic       s1_shen_q;
  logic [3:0] s1_amt_q;
  logic       s1_up_q;
  logic       s1_lo_q;

  logic       s2_v_q;
  logic [7:0] s2_byte_q;

  logic       v_q;
  logic [7:0] dout_q, dout_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic [7:0] base;
  logic [7:0] offset;
  logic [5:0] sum_raw;
  logic [5:0] sum_wrap;
  logic [7:0] shifted;
  logic [7:0] key_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      v_q    <= 1'b0;
      dout_q <= 8'h00;
      cnt_q  <= 3'd0;
      ptr_q  <= 2'd0;
    end else begin
      s1_v_q <= en;
      s2_v_q <= s1_v_q;
      v_q    <= s2_v_q;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
    end
  end

  // Payload registers carry no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_byte_q <= din;
      s1_shen_q <= shift_en;
      s1_amt_q  <= shift_amt;
      s1_up_q   <= (din >= 8'h41) && (din <= 8'h5A);
      s1_lo_q   <= (din >= 8'h61) && (din <= 8'h7A);
    end
    if (s1_v_q) begin
      s2_byte_q <= shifted;
    end
  end

  // Offset is at most 25 and shift at most 15, so one subtraction of 26 covers the wrap.
  always_comb begin
    base     = s1_up_q ? 8'h41 : 8'h61;
    offset   = s1_byte_q - base;
    sum_raw  = {1'b0, offset[4:0]} + {2'b00, s1_amt_q};
    sum_wrap = (sum_raw >= 6'd26) ? (sum_raw - 6'd26) : sum_raw;
    shifted  = s1_byte_q;
    if (s1_shen_q && (s1_up_q || s1_lo_q)) begin
      shifted = base + {2'b00, sum_wrap};
    end
  end

  always_comb begin
    key_sel = k1;
    if (mode) begin
      case (ptr_q)
        2'd1:    key_sel = k2;
        2'd2:    key_sel = k3;
        default: key_sel = k1;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    dout_d = dout_q;
    if (s2_v_q) begin
      dout_d = s2_byte_q ^ key_sel;
    end
    if (!mode) begin
      cnt_d = 3'd0;
      ptr_d = 2'd0;
    end else if (s2_v_q) begin
      if (cnt_q == rot_freq) begin
        cnt_d = 3'd0;
        ptr_d = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  assign v    = v_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_encrypt_pipe.sv
// tb/tb_encrypt_pipe.sv - scoreboard bench for encrypt_pipe using directed vectors.
// Drivers queue expected byte plus arrival cycle; a negedge monitor checks every v pulse.
module tb_encrypt_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       shift_en;
  logic [3:0] shift_amt;
  logic       mode;
  logic       v;
  logic [7:0] dout;

  typedef struct {
    logic [7:0]  d;
    int unsigned c;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  encrypt_pipe dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .k1(k1), .k2(k2), .k3(k3), .rot_freq(rot_freq),
    .shift_en(shift_en), .shift_amt(shift_amt), .mode(mode),
    .v(v), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_v: got v=1 dout=%02h at cycle %0d, required no output", dout, cyc);
      end else begin
        e = sb_q.pop_front();
        if (dout !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL out_byte: got dout=%02h at cycle %0d, required %02h at cycle %0d",
                   dout, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic se, input logic [3:0] amt,
                      input logic [7:0] x);
    @(negedge clk);
    en        = 1'b1;
    din       = d;
    shift_en  = se;
    shift_amt = amt;
    sb_q.push_back('{d: x, c: cyc + 3});
  endtask

  task automatic send_raw(input logic [7:0] d);
    @(negedge clk);
    en  = 1'b1;
    din = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int left;
    idle(1);
    left = 20;
    while (sb_q.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_%s: got %0d bytes outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h", name, got, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = 8'h00;
    k1 = 8'h00; k2 = 8'h00; k3 = 8'h00;
    rot_freq = 3'd0; shift_en = 1'b0; shift_amt = 4'd0; mode = 1'b0;
    @(negedge clk);
    check8("reset_v", {7'd0, v}, 8'h00);
    check8("reset_dout", dout, 8'h00);
    rst = 1'b0;

    k1 = 8'h00;
    send(8'h41, 1'b1, 4'd3, 8'h44);
    drain("basic");

    k1 = 8'hFF;
    send(8'h7A, 1'b1, 4'd3, 8'h9C);
    drain("wrap_xor");

    k1 = 8'h00;
    send(8'h5A, 1'b1, 4'd15, 8'h4F);
    send(8'h61, 1'b1, 4'd0,  8'h61);
    send(8'h40, 1'b1, 4'd5,  8'h40);
    send(8'h5B, 1'b1, 4'd5,  8'h5B);
    send(8'h60, 1'b1, 4'd1,  8'h60);
    send(8'h7B, 1'b1, 4'd1,  8'h7B);
    send(8'h41, 1'b1, 4'd1,  8'h42);
    send(8'h79, 1'b1, 4'd2,  8'h61);
    send(8'h41, 1'b0, 4'd3,  8'h41);
    drain("edges");

    k1 = 8'h0F;
    send(8'h35, 1'b1, 4'd15, 8'h3A);
    drain("nonalpha");

    mode = 1'b1; rot_freq = 3'd1;
    k1 = 8'h01; k2 = 8'h02; k3 = 8'h04;
    send(8'h00, 1'b0, 4'd0, 8'h01);
    send(8'h00, 1'b0, 4'd0, 8'h01);
    send(8'h00, 1'b0, 4'd0, 8'h02);
    send(8'h00, 1'b0, 4'd0, 8'h02);
    send(8'h00, 1'b0, 4'd0, 8'h04);
    send(8'h00, 1'b0, 4'd0, 8'h04);
    send(8'h00, 1'b0, 4'd0, 8'h01);
    drain("rotate");

    mode = 1'b0;
    idle(1);
    mode = 1'b1;
    send(8'h00, 1'b0, 4'd0, 8'h01); idle(1);
    send(8'h00, 1'b0, 4'd0, 8'h01); idle(2);
    send(8'h00, 1'b0, 4'd0, 8'h02); idle(1);
    send(8'h00, 1'b0, 4'd0, 8'h02); idle(3);
    send(8'h00, 1'b0, 4'd0, 8'h04); idle(1);
    send(8'h00, 1'b0, 4'd0, 8'h04); idle(2);
    send(8'h00, 1'b0, 4'd0, 8'h01);
    drain("bubbles");

    mode = 1'b0;
    idle(1);
    mode = 1'b1; rot_freq = 3'd0;
    send(8'h00, 1'b0, 4'd0, 8'h01);
    send(8'h00, 1'b0, 4'd0, 8'h02);
    send(8'h00, 1'b0, 4'd0, 8'h04);
    send(8'h00, 1'b0, 4'd0, 8'h01);
    drain("rot0");

    mode = 1'b0;
    idle(1);
    mode = 1'b1;
    send(8'h00, 1'b0, 4'd0, 8'h01);
    drain("mode_clear");

    k1 = 8'h11; k2 = 8'h22; k3 = 8'h33;
    send_raw(8'h00);
    send_raw(8'h00);
    send_raw(8'h00);
    @(posedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b1;
    #1;
    check8("async_rst_v", {7'd0, v}, 8'h00);
    check8("async_rst_dout", dout, 8'h00);
    idle(2);
    rst = 1'b0;
    idle(3);
    send(8'h00, 1'b0, 4'd0, 8'h11);
    send(8'h00, 1'b0, 4'd0, 8'h22);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
